ioctl_sdram_loader: RTL

- Sits between data_io and the sdram controller's write port, replacing the bare toggle-per-byte download logic.
- Captures the ioctl byte stream and merges even/odd byte pairs into 16-bit word writes.
- Buffers the writes in a small FIFO and issues them over the sdram toggle req/ack handshake.
- Drives rom_loaded and the core reset once the FIFO has fully drained after download ends.

---
 rtl/ioctl_sdram_loader_if.sv | 20 ++
 rtl/ioctl_sdram_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_sdram_loader_if.sv
// SDRAM write-port bundle between the ioctl loader and the sdram controller.
// The loader is the master; port_ack comes back from the controller.
interface ioctl_sdram_loader_if;
  logic        port_req;
  logic        port_ack;
  logic [22:0] port_a;
  logic [1:0]  port_ds;
  logic [15:0] port_d;
  logic        port_we;

  modport master (
    output port_req, port_a, port_ds, port_d, port_we,
    input  port_ack
  );

  modport slave (
    input  port_req, port_a, port_ds, port_d, port_we,
    output port_ack
  );
endinterface

// File: rtl/ioctl_sdram_loader.sv
// ioctl byte stream -> paired 16-bit SDRAM writes through a small FIFO and toggle req/ack.
// Optional macro LOADER_STATS_EN adds byte_count/checksum outputs.
module ioctl_sdram_loader #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [24:0] ADDR_OFFSET = 25'h0000000
) (
  input  logic                 clk_sys,
  input  logic                 res_n,
  input  logic                 ioctl_download,
  input  logic                 ioctl_wr,
  input  logic [24:0]          ioctl_addr,
  input  logic [7:0]           ioctl_dout,
  ioctl_sdram_loader_if.master sdram,
  output logic                 busy,
  output logic                 overflow,
  output logic                 rom_loaded,
  output logic                 core_reset
`ifdef LOADER_STATS_EN
  ,
  output logic [24:0]          byte_count,
  output logic [15:0]          checksum
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } entry_t;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  logic        wr_q, dl_q;
  logic        wr_rise, dl_rise, dl_fall;
  logic [24:0] byte_a;

  always_ff @(posedge clk_sys) begin
    if (!res_n) begin
      wr_q <= 1'b0;
      dl_q <= 1'b0;
    end else begin
      wr_q <= ioctl_wr;
      dl_q <= ioctl_download;
    end
  end

  assign wr_rise = ioctl_wr & ~wr_q & ioctl_download;
  assign dl_rise = ioctl_download & ~dl_q;
  assign dl_fall = ~ioctl_download & dl_q;
  assign byte_a  = ioctl_addr - ADDR_OFFSET;

  // Holding register for an even byte waiting for its odd partner
  logic        h_vld_q, h_vld_d;
  logic [23:0] h_addr_q, h_addr_d;
  logic [7:0]  h_lo_q, h_lo_d;
  logic        ev0_vld, ev1_vld;
  entry_t      ev0, ev1, h_entry;

  always_comb begin
    h_vld_d  = h_vld_q;
    h_addr_d = h_addr_q;
    h_lo_d   = h_lo_q;
    ev0_vld  = 1'b0;
    ev0      = '0;
    ev1_vld  = 1'b0;
    ev1      = '0;
    h_entry  = {h_addr_q[22:0], 2'b01, 8'h00, h_lo_q};
    if (wr_rise) begin
      if (!byte_a[0]) begin
        ev0_vld  = h_vld_q;
        ev0      = h_entry;
        h_vld_d  = 1'b1;
        h_addr_d = byte_a[24:1];
        h_lo_d   = ioctl_dout;
      end else if (h_vld_q && (byte_a[24:1] == h_addr_q)) begin
        ev0_vld = 1'b1;
        ev0     = {h_addr_q[22:0], 2'b11, ioctl_dout, h_lo_q};
        h_vld_d = 1'b0;
      end else begin
        ev0_vld = 1'b1;
        ev1_vld = h_vld_q;
        if (h_vld_q) begin
          ev0 = h_entry;
          ev1 = {byte_a[23:1], 2'b10, ioctl_dout, 8'h00};
        end else begin
          ev0 = {byte_a[23:1], 2'b10, ioctl_dout, 8'h00};
        end
        h_vld_d = 1'b0;
      end
    end else if (dl_fall && h_vld_q) begin
      ev0_vld = 1'b1;
      ev0     = h_entry;
      h_vld_d = 1'b0;
    end
  end

  // A second push in one cycle waits in pend; strobe spacing keeps pend single-deep
  logic   pend_vld_q, pend_vld_d;
  entry_t pend_q, pend_d;
  logic   push_vld;
  entry_t push_ent;

  assign push_vld   = pend_vld_q | ev0_vld;
  assign push_ent   = pend_vld_q ? pend_q : ev0;
  assign pend_vld_d = pend_vld_q ? ev0_vld : ev1_vld;
  assign pend_d     = pend_vld_q ? ev0 : ev1;

  always_ff @(posedge clk_sys) begin
    if (!res_n) begin
      h_vld_q    <= 1'b0;
      pend_vld_q <= 1'b0;
    end else begin
      h_vld_q    <= h_vld_d;
      pend_vld_q <= pend_vld_d;
    end
    h_addr_q <= h_addr_d;
    h_lo_q   <= h_lo_d;
    pend_q   <= pend_d;
  end

  entry_t           mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wp_q, rp_q;
  logic [PTR_W:0]   cnt_q;
  logic             fifo_empty, fifo_full, pop, push_ok, ovf_q;
  entry_t           head;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == DEPTH_C);
  assign push_ok    = push_vld & (~fifo_full | pop);
  assign head       = mem_q[rp_q];

  always_ff @(posedge clk_sys) begin
    if (push_ok) mem_q[wp_q] <= push_ent;
  end

  always_ff @(posedge clk_sys) begin
    if (!res_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push_ok) wp_q <= wp_q + 1'b1;
      if (pop)     rp_q <= rp_q + 1'b1;
      if (push_ok && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (!push_ok && pop) cnt_q <= cnt_q - 1'b1;
      if (push_vld && !push_ok) ovf_q <= 1'b1;
    end
  end

  state_t state_q, state_d;
  logic   req_q, we_q, ack_match;
  entry_t out_q;

  always_ff @(posedge clk_sys) begin
    if (!res_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!fifo_empty) state_d = S_WAIT;
      S_WAIT:  if (sdram.port_ack == req_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pop       = (state_q == S_IDLE) & ~fifo_empty;
    ack_match = (state_q == S_WAIT) & (sdram.port_ack == req_q);
  end

  // Port registers hold their value across WAIT so the controller sees a stable request
  always_ff @(posedge clk_sys) begin
    if (!res_n) begin
      req_q <= 1'b0;
      we_q  <= 1'b0;
      out_q <= '0;
    end else if (pop) begin
      req_q <= ~req_q;
      we_q  <= 1'b1;
      out_q <= head;
    end else if (ack_match) begin
      we_q  <= 1'b0;
    end
  end

  assign sdram.port_req = req_q;
  assign sdram.port_we  = we_q;
  assign sdram.port_a   = out_q.a;
  assign sdram.port_ds  = out_q.ds;
  assign sdram.port_d   = out_q.d;

  logic seen_q, rom_q, rom_d, core_rst_q, all_idle;

  assign all_idle = ~h_vld_q & ~pend_vld_q & fifo_empty & (state_q == S_IDLE);

  always_comb begin
    rom_d = rom_q;
    if (dl_rise) rom_d = 1'b0;
    else if (!ioctl_download && seen_q && all_idle) rom_d = 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (!res_n) begin
      seen_q     <= 1'b0;
      rom_q      <= 1'b0;
      core_rst_q <= 1'b1;
    end else begin
      if (ioctl_download) seen_q <= 1'b1;
      rom_q      <= rom_d;
      core_rst_q <= ~rom_q | ioctl_download;
    end
  end

  assign busy       = ~fifo_empty | h_vld_q | pend_vld_q | (state_q == S_WAIT);
  assign overflow   = ovf_q;
  assign rom_loaded = rom_q;
  assign core_reset = core_rst_q;

`ifdef LOADER_STATS_EN
  logic [24:0] bc_q;
  logic [15:0] cs_q;

  always_ff @(posedge clk_sys) begin
    if (!res_n || dl_rise) begin
      bc_q <= '0;
      cs_q <= '0;
    end else if (push_ok) begin
      bc_q <= bc_q + 25'(push_ent.ds[1]) + 25'(push_ent.ds[0]);
      cs_q <= cs_q + {8'h00, push_ent.d[15:8] & {8{push_ent.ds[1]}}}
                   + {8'h00, push_ent.d[7:0]  & {8{push_ent.ds[0]}}};
    end
  end

  assign byte_count = bc_q;
  assign checksum   = cs_q;
`endif

endmodule
